// File: rtl/types_pkg.sv
// Shared types for the commit-side retire logic: FSM state, ROB head record
// and the architectural register count.
package types_pkg;

  localparam int ARCH_REGS   = 32;
  localparam int HEAD_ROB_W  = 5;
  localparam int HEAD_PREG_W = 7;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } retire_state_t;

  typedef struct packed {
    logic [4:0]             rd;
    logic [HEAD_PREG_W-1:0] pd_new;
    logic [HEAD_PREG_W-1:0] pd_old;
    logic                   is_store;
    logic [HEAD_ROB_W-1:0]  tag;
  } rob_head_t;

endpackage

// File: rtl/commit_map.sv
// Committed register alias table (CRAT): one write port fed by retirement,
// one read port addressed by the recovery index. Reset restores identity.
module commit_map #(
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_idx,
  input  logic [PREG_W-1:0] wr_preg,
  input  logic [4:0]        rd_idx,
  output logic [PREG_W-1:0] rd_preg
);

  logic [PREG_W-1:0] map_q [ARCH_REGS];

  // Identity mapping on reset, otherwise record the retiring mapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= PREG_W'(i);
      end
    end else if (wr_en && (int'(wr_idx) < ARCH_REGS)) begin
      map_q[wr_idx] <= wr_preg;
    end
  end

  assign rd_preg = map_q[rd_idx];

endmodule

// File: rtl/rob_retire.sv
// In-order single-wide retirement from the ROB head. Updates the CRAT, hands
// superseded physical registers to the free list through a one-entry release
// buffer, signals store commit and replays the CRAT into the RAT on request.
// Optional performance counters are built when RETIRE_PERF_EN is defined.
//
// Handshake: the release buffer offers free_preg while free_valid is high;
// the transfer happens in any cycle where free_valid && free_ready, and
// free_preg holds steady while free_valid && !free_ready.
module rob_retire #(
  parameter int ROB_W     = 5,
  parameter int PREG_W    = 7,
  parameter int ARCH_REGS = types_pkg::ARCH_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              head_valid,
  input  logic              head_done,
  input  logic [ROB_W-1:0]  head_tag,
  input  logic [4:0]        head_rd,
  input  logic [PREG_W-1:0] head_pd_new,
  input  logic [PREG_W-1:0] head_pd_old,
  input  logic              head_is_store,
  output logic              rob_pop,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  input  logic              free_ready,
  output logic              store_commit,
  output logic [ROB_W-1:0]  store_tag,
  input  logic              recover_req,
  output logic              rat_wr_en,
  output logic [4:0]        rat_wr_idx,
  output logic [PREG_W-1:0] rat_wr_preg,
  output logic              recover_done,
  output logic [31:0]       perf_instret,
  output logic [31:0]       perf_stall
);

  import types_pkg::*;

  localparam logic [4:0] LAST_IDX = 5'(ARCH_REGS - 1);

  retire_state_t     state, state_next;
  logic [4:0]        idx_q, idx_next;
  logic              done_q, done_next;
  logic              retire, recovering, has_rd;
  logic              buf_valid;
  logic [PREG_W-1:0] buf_preg;
  logic [PREG_W-1:0] map_rd_preg;

  assign has_rd = (head_rd != 5'd0);

  // Next-state logic: retire decision in RUN, index walk in RECOVER.
  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    done_next  = 1'b0;
    recovering = 1'b0;
    retire     = 1'b0;
    case (state)
      RUN: begin
        if (recover_req) begin
          state_next = RECOVER;
          idx_next   = 5'd1;
        end else begin
          retire = head_valid && head_done && (!has_rd || !buf_valid || free_ready);
        end
      end
      RECOVER: begin
        recovering = 1'b1;
        idx_next   = idx_q + 5'd1;
        if (idx_q == LAST_IDX) begin
          state_next = RUN;
          done_next  = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State register; reset aborts any recovery without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      idx_q  <= 5'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      idx_q  <= idx_next;
      done_q <= done_next;
    end
  end

  // Release buffer: a reload in the drain cycle takes priority over clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_preg  <= '0;
    end else if (retire && has_rd) begin
      buf_valid <= 1'b1;
      buf_preg  <= head_pd_old;
    end else if (buf_valid && free_ready) begin
      buf_valid <= 1'b0;
    end
  end

  commit_map #(
    .ARCH_REGS (ARCH_REGS),
    .PREG_W    (PREG_W)
  ) u_commit_map (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rob_pop && has_rd),
    .wr_idx  (head_rd),
    .wr_preg (head_pd_new),
    .rd_idx  (idx_q),
    .rd_preg (map_rd_preg)
  );

  // Pulses are held low while reset is asserted.
  assign rob_pop      = retire && !reset;
  assign store_commit = rob_pop && head_is_store;
  assign store_tag    = store_commit ? head_tag : '0;
  assign free_valid   = buf_valid && !reset;
  assign free_preg    = buf_preg;
  assign rat_wr_en    = recovering && !reset;
  assign rat_wr_idx   = idx_q;
  assign rat_wr_preg  = map_rd_preg;
  assign recover_done = done_q && !reset;

`ifdef RETIRE_PERF_EN
  logic [31:0] instret_q, stall_q;

  // Retired-instruction and head-blocked cycle counters, wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      if (rob_pop) instret_q <= instret_q + 32'd1;
      if ((state == RUN) && head_valid && !rob_pop) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_instret = instret_q;
  assign perf_stall   = stall_q;
`else
  assign perf_instret = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: a queue-based reference model is checked
// against the DUT on every falling edge, plus literal expectations per test.
module tb_rob_retire;

  localparam int NREG = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       head_valid, head_done, head_is_store;
  logic [4:0] head_tag, head_rd;
  logic [6:0] head_pd_new, head_pd_old;
  logic       rob_pop, free_valid, free_ready, store_commit;
  logic [6:0] free_preg, rat_wr_preg;
  logic [4:0] store_tag, rat_wr_idx;
  logic       recover_req, rat_wr_en, recover_done;
  logic [31:0] perf_instret, perf_stall;

  int compared   = 0;
  int mismatched = 0;

  // Clock.
  always #5 clk = ~clk;

  rob_retire dut (
    .clk           (clk),
    .reset         (reset),
    .head_valid    (head_valid),
    .head_done     (head_done),
    .head_tag      (head_tag),
    .head_rd       (head_rd),
    .head_pd_new   (head_pd_new),
    .head_pd_old   (head_pd_old),
    .head_is_store (head_is_store),
    .rob_pop       (rob_pop),
    .free_valid    (free_valid),
    .free_preg     (free_preg),
    .free_ready    (free_ready),
    .store_commit  (store_commit),
    .store_tag     (store_tag),
    .recover_req   (recover_req),
    .rat_wr_en     (rat_wr_en),
    .rat_wr_idx    (rat_wr_idx),
    .rat_wr_preg   (rat_wr_preg),
    .recover_done  (recover_done),
    .perf_instret  (perf_instret),
    .perf_stall    (perf_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: committed map, release-buffer contents, pending
  // recovery writes and counters.
  int          m_crat [NREG];
  int          m_free [$];
  int          m_rec  [$];
  bit          m_done;
  int unsigned m_instret, m_stall;

  always @(negedge clk) begin
    bit rec, exp_pop, nd;
    if (reset) begin
      chk("rst_rob_pop", rob_pop, 0);
      chk("rst_store_commit", store_commit, 0);
      chk("rst_store_tag", store_tag, 0);
      chk("rst_free_valid", free_valid, 0);
      chk("rst_rat_wr_en", rat_wr_en, 0);
      chk("rst_recover_done", recover_done, 0);
      for (int i = 0; i < NREG; i++) m_crat[i] = i;
      m_free.delete();
      m_rec.delete();
      m_done = 0;
      m_instret = 0;
      m_stall = 0;
    end else begin
      rec = (m_rec.size() != 0);
      exp_pop = !rec && !recover_req && head_valid && head_done &&
                (head_rd == 0 || m_free.size() == 0 || free_ready);
      chk("m_rob_pop", rob_pop, exp_pop);
      chk("m_store_commit", store_commit, exp_pop && head_is_store);
      if (exp_pop && head_is_store) chk("m_store_tag", store_tag, head_tag);
      chk("m_free_valid", free_valid, m_free.size() != 0);
      if (m_free.size() != 0) chk("m_free_preg", free_preg, m_free[0]);
      chk("m_rat_wr_en", rat_wr_en, rec);
      if (rec) begin
        chk("m_rat_wr_idx", rat_wr_idx, m_rec[0]);
        chk("m_rat_wr_preg", rat_wr_preg, m_crat[m_rec[0]]);
      end
      chk("m_recover_done", recover_done, m_done);
`ifdef RETIRE_PERF_EN
      chk("m_perf_instret", perf_instret, m_instret);
      chk("m_perf_stall", perf_stall, m_stall);
`else
      chk("m_perf_instret", perf_instret, 0);
      chk("m_perf_stall", perf_stall, 0);
`endif
      nd = rec && (m_rec.size() == 1);
      if (rec) void'(m_rec.pop_front());
      else if (recover_req) for (int i = 1; i < NREG; i++) m_rec.push_back(i);
      if (exp_pop) begin
        m_instret++;
        if (head_rd != 0) m_crat[head_rd] = int'(head_pd_new);
      end
      if (!rec && head_valid && !exp_pop) m_stall++;
      if (m_free.size() != 0 && free_ready) void'(m_free.pop_front());
      if (exp_pop && head_rd != 0) m_free.push_back(int'(head_pd_old));
      m_done = nd;
    end
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_head(input bit v, input bit d, input int tag, input int rd,
                          input int pn, input int po, input bit st);
    head_valid    = v;
    head_done     = d;
    head_tag      = 5'(tag);
    head_rd       = 5'(rd);
    head_pd_new   = 7'(pn);
    head_pd_old   = 7'(po);
    head_is_store = st;
  endtask

  // Full recovery with a duplicate request mid-walk; pin_idx==0 means the
  // CRAT is expected to be identity, otherwise only pin_idx is pinned.
  task automatic run_recover(input int pin_idx, input int pin_val);
    recover_req = 1'b1;
    @(negedge clk);
    chk("req_rob_pop", rob_pop, 0);
    chk("req_rat_wr_en", rat_wr_en, 0);
    step();
    for (int k = 1; k < NREG; k++) begin
      recover_req = (k == 5);
      @(negedge clk);
      chk("rec_wr_en", rat_wr_en, 1);
      chk("rec_wr_idx", rat_wr_idx, k);
      chk("rec_rob_pop", rob_pop, 0);
      chk("rec_done_early", recover_done, 0);
      if (pin_idx == 0) chk("rec_identity", rat_wr_preg, k);
      else if (k == pin_idx) chk("rec_pinned", rat_wr_preg, pin_val);
      step();
    end
    recover_req = 1'b0;
    @(negedge clk);
    chk("rec_done", recover_done, 1);
    chk("rec_wr_en_off", rat_wr_en, 0);
    step();
  endtask

  initial begin
    reset = 1'b1;
    free_ready = 1'b1;
    recover_req = 1'b0;
    set_head(1, 1, 0, 0, 0, 0, 0);
    // Reset: pulses must stay low even with a done head.
    @(negedge clk);
    chk("reset_pop", rob_pop, 0);
    repeat (3) step();
    reset = 1'b0;
    set_head(0, 0, 0, 0, 0, 0, 0);
    step();

    // Identity CRAT visible through a recovery walk.
    run_recover(0, 0);

    // Back-to-back retirement.
    set_head(1, 1, 1, 5, 40, 5, 0);
    @(negedge clk);
    chk("b2b_pop0", rob_pop, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      set_head(1, 1, 2 + i, 6 + i, 50 + i, 20 + i, 0);
      @(negedge clk);
      chk("b2b_pop", rob_pop, 1);
      chk("b2b_free_valid", free_valid, 1);
      chk("b2b_free_preg", free_preg, (i == 0) ? 5 : 19 + i);
      step();
    end
    set_head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_last_free", free_preg, 23);
    step();
    @(negedge clk);
    chk("b2b_drained", free_valid, 0);
    step();

    // Free-list backpressure.
    free_ready = 1'b0;
    set_head(1, 1, 6, 10, 60, 30, 0);
    @(negedge clk);
    chk("bp_first_pop", rob_pop, 1);
    step();
    set_head(1, 1, 7, 11, 61, 31, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_stall_pop", rob_pop, 0);
      chk("bp_free_hold", free_preg, 30);
      step();
    end
    // Store with no destination retires while the buffer is full.
    set_head(1, 1, 9, 0, 0, 0, 1);
    @(negedge clk);
    chk("st_pop", rob_pop, 1);
    chk("st_commit", store_commit, 1);
    chk("st_tag", store_tag, 9);
    step();
    set_head(1, 1, 7, 11, 61, 31, 0);
    free_ready = 1'b1;
    @(negedge clk);
    chk("bp_after_store", free_preg, 30);
    chk("bp_drain_pop", rob_pop, 1);
    step();
    set_head(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bp_reload_valid", free_valid, 1);
    chk("bp_reload_preg", free_preg, 31);
    step();

    // Recovery carrying a modified entry.
    set_head(1, 1, 10, 3, 77, 3, 0);
    @(negedge clk);
    chk("rc_pop", rob_pop, 1);
    step();
    set_head(1, 1, 11, 0, 0, 0, 0);
    run_recover(3, 77);
    set_head(0, 0, 0, 0, 0, 0, 0);
    step();

    // Reset in the middle of a recovery walk.
    recover_req = 1'b1;
    step();
    recover_req = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      chk("mid_idx", rat_wr_idx, k);
      step();
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr_en", rat_wr_en, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      chk("mid_no_done", recover_done, 0);
      chk("mid_no_wr", rat_wr_en, 0);
      step();
    end
    run_recover(0, 0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
